// File: rtl/serial_cmp_pkg.sv
// Shared definitions for the bit-serial comparator controller: state
// encoding, default operand width and the counter-width helper.
package serial_cmp_pkg;

    localparam int CMP_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Bits needed to count from 0 up to and including width.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/cmp_bit_di.sv
// One-bit right-to-left comparator cell. The chain input n carries the
// verdict of the less significant bits; a differing bit at this position
// overrides it, equal bits pass it through unchanged.
module cmp_bit_di (
    input  logic n,
    input  logic a,
    input  logic b,
    output logic z
);

    // Higher bit decides when it differs, otherwise the incoming chain wins.
    always_comb begin
        z = (n & (~a | b)) | (~a & b);
    end

endmodule

// File: rtl/serial_cmp_di_ctrl.sv
// Bit-serial magnitude comparator controller. Captures an operand pair on
// start, walks them LSB-first through a single cmp_bit_di cell over WIDTH
// cycles and reports A < B (le_mode=0) or A <= B (le_mode=1) on z, with a
// one-cycle done pulse and a result held until the next comparison.
// Optional feature: define SERIAL_CMP_EQ_FLAG_EN to add the eq output,
// which flags that the two captured operands were identical.
module serial_cmp_di_ctrl
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             le_mode,
    output logic             busy,
    output logic             done,
`ifdef SERIAL_CMP_EQ_FLAG_EN
    output logic             eq,
`endif
    output logic             z
);

    localparam int            CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic               n_reg_q, n_reg_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               z_q, z_d;
    logic               cell_z;

`ifdef SERIAL_CMP_EQ_FLAG_EN
    logic               eq_run_q, eq_run_d;
    logic               eq_q, eq_d;
`endif

    cmp_bit_di u_cell (
        .n (n_reg_q),
        .a (a_sh_q[0]),
        .b (b_sh_q[0]),
        .z (cell_z)
    );

    // Next-state logic: load on accepted start, shift one bit per cycle,
    // publish the final chain value on the last shift.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        n_reg_d = n_reg_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        z_d     = z_q;
`ifdef SERIAL_CMP_EQ_FLAG_EN
        eq_run_d = eq_run_q;
        eq_d     = eq_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    n_reg_d = le_mode;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
`ifdef SERIAL_CMP_EQ_FLAG_EN
                    eq_run_d = 1'b1;
`endif
                end
            end
            ST_SHIFT: begin
                n_reg_d = cell_z;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                cnt_d   = cnt_q + CW'(1);
`ifdef SERIAL_CMP_EQ_FLAG_EN
                if (a_sh_q[0] != b_sh_q[0]) begin
                    eq_run_d = 1'b0;
                end
`endif
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                    z_d     = cell_z;
                    done_d  = 1'b1;
`ifdef SERIAL_CMP_EQ_FLAG_EN
                    eq_d    = eq_run_q & (a_sh_q[0] == b_sh_q[0]);
`endif
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight comparison.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            n_reg_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            n_reg_q <= n_reg_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            z_q     <= z_d;
        end
    end

`ifdef SERIAL_CMP_EQ_FLAG_EN
    // Sticky equality tracker and its held copy published with z.
    always_ff @(posedge clk) begin
        if (reset) begin
            eq_run_q <= 1'b0;
            eq_q     <= 1'b0;
        end else begin
            eq_run_q <= eq_run_d;
            eq_q     <= eq_d;
        end
    end

    assign eq = eq_q;
`endif

    assign busy = busy_q;
    assign done = done_q;
    assign z    = z_q;

endmodule

// File: doc/serial_cmp_di_ctrl.md
# serial_cmp_di_ctrl

- Bit-serial magnitude comparator controller that sequences a single right-to-left (LSB-first) comparator cell over `WIDTH` cycles.
- Reports `A < B` (strict mode) or `A <= B` (inclusive mode).
- Sits between a requester issuing operand pairs and the one-bit comparator cell, replacing a `WIDTH`-cell ripple chain with one cell plus sequencing.
- Uses a start/busy/done handshake with a held result.

## Interface
- `WIDTH`, default 8: operand width in bits; legal range 1..32.
- `clk`  input  1  rising-edge clock; the only clock.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  request a comparison; sampled only in IDLE.
- `a`  input  WIDTH  operand A; captured on the accepted `start`.
- `b`  input  WIDTH  operand B; captured on the accepted `start`.
- `le_mode`  input  1  captured on the accepted `start`; 0 selects `A < B`, 1 selects `A <= B`.
- `busy`  output  1  high while a comparison is in flight (SHIFT and DONE).
- `done`  output  1  one-cycle pulse when `z` becomes valid.
- `z`  output  1  comparison result; held until the next result is produced.

## Operation
- Cell function, per bit i, with chain bit `n`: `n_next = (n & (~a_i | b_i)) | (~a_i & b_i)`.
  - a_i < b_i: `n_next` = 1.
  - a_i > b_i: `n_next` = 0.
  - a_i == b_i: `n_next` = `n`.
- Chain seed is `le_mode`. After all bits, the final chain value is the answer, because the MSB decides last.
- Registers:
  - `a_sh` and `b_sh`: WIDTH-bit shift registers.
  - `n_reg`: 1-bit chain register.
  - `cnt`: counter of width `$clog2(WIDTH+1)`.
  - `state`.
- FSM states:
  - IDLE:
    - `start`=1: load `a_sh`=`a`, `b_sh`=`b`, `n_reg`=`le_mode`, `cnt`=0, then go to SHIFT.
    - Otherwise stay in IDLE.
  - SHIFT:
    - Each cycle: `n_reg` <= cell(`n_reg`, `a_sh[0]`, `b_sh[0]`), shift both registers right by one (zero fill), `cnt`++.
    - When `cnt` == WIDTH-1 in this cycle, go to DONE and load `z` <= that cycle's cell output.
  - DONE: assert `done`, then go to IDLE unconditionally.
- `start` outside IDLE, including the DONE cycle, is ignored. No queuing.
- Changes to `a`/`b`/`le_mode` after capture have no effect.
- `reset` (any state, including mid-SHIFT):
  - Next cycle: `state`=IDLE, `busy`=0, `done`=0, `z`=0, `cnt`=0, `n_reg`=0, shift registers 0.
  - The in-flight comparison is discarded and no `done` is produced for it.
- `reset` and `start` in the same cycle: reset wins and `start` is dropped.

## Timing
- `start` accepted at cycle T (IDLE):
  - SHIFT occupies cycles T+1 .. T+WIDTH.
  - DONE is at cycle T+WIDTH+1: `done`=1 and `z` is valid.
  - IDLE resumes at T+WIDTH+2.
- Latency from `start` to `done` is WIDTH+1 cycles.
- Maximum throughput is one comparison per WIDTH+2 cycles.
- `busy` is high from T+1 through T+WIDTH+1 inclusive and low in IDLE.
- `z` is registered and changes only on the DONE-entry edge or on reset.
- WIDTH=1: a single SHIFT cycle, so `done` comes at T+2.

## Configuration
- Macro: `SERIAL_CMP_EQ_FLAG_EN`.
- Defined:
  - Adds output `eq` (1 bit, reset 0).
  - A sticky equality register is set to 1 on the accepted `start` and cleared in any SHIFT cycle where `a_sh[0] != b_sh[0]`.
  - `eq` is loaded together with `z` on DONE entry and held in the same way as `z`.
  - For `a` == `b`: `eq`=1, and `z` equals `le_mode`.
- Undefined: no `eq` port and no equality register. Behaviour is otherwise identical.

## Structure
- Package `serial_cmp_pkg`:
  - state encoding constants `ST_IDLE`=2'd0, `ST_SHIFT`=2'd1, `ST_DONE`=2'd2.
  - `CMP_WIDTH_DEFAULT`=8.
  - `cnt_w` function (`$clog2(WIDTH+1)`).
- Sub-module `cmp_bit_di`:
  - Purely combinational one-bit cell with inputs `n`, `a`, `b` and output `z`, implementing the cell equation above.
  - Instantiated once in the controller.
  - Verified standalone against all 8 input combinations.

## Test plan
- WIDTH=8, `a`=0x35, `b`=0x36, `le_mode`=0: `start` at T -> `busy` high T+1..T+9, `done` pulse at T+9, `z`=1.
- `a`=`b`=0xA5: `le_mode`=0 gives `z`=0; `le_mode`=1 gives `z`=1. With `SERIAL_CMP_EQ_FLAG_EN`, `eq`=1 in both cases.
- `a`=0x80, `b`=0x7F, `le_mode`=1 -> `z`=0 (MSB dominates); then `a`=0x7F, `b`=0x80 -> `z`=1, `eq`=0.
- `start` held high continuously with changing operands -> only the IDLE-sampled pairs are compared, `done` pulses exactly every 10 cycles, and operand changes mid-SHIFT do not alter `z`.
- `reset` asserted at T+4 of a comparison -> next cycle `busy`=0, `z`=0, and no `done` ever follows; a new `start` afterwards completes normally with `done` at +9.
- WIDTH=1 build: `a`=0, `b`=1, `le_mode`=0 -> `done` at T+2 with `z`=1; `a`=1, `b`=0 -> `z`=0.
